// File: rtl/base_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------
// base_pkg : shared defaults and event encoding for base tracking
// Rev 1.0
// ---------------------------------------------------------------
package base_pkg;
   localparam int NBASE_DEF       = 3;
   localparam int RUN_W_DEF       = 5;
   localparam int OUTS_PER_INNING = 3;

   typedef enum logic [1:0] {
      EV_NONE = 2'd0,
      EV_WALK = 2'd1,
      EV_HIT  = 2'd2,
      EV_OUT  = 2'd3
   } event_e;

   // Simultaneous strobes resolve first-to-last in this order.
   localparam event_e PRIO_1ST = EV_OUT;
   localparam event_e PRIO_2ND = EV_HIT;
   localparam event_e PRIO_3RD = EV_WALK;
endpackage
`default_nettype wire

// File: rtl/base_runner_tracker_if.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------
// base_runner_tracker_if : event strobes in, game state out
// Rev 1.0
// ---------------------------------------------------------------
interface base_runner_tracker_if
   import base_pkg::*;
#(
   parameter int NBASE = NBASE_DEF,
   parameter int RUN_W = RUN_W_DEF,
   parameter int ADV_W = $clog2(NBASE + 2)
);
   logic             iRESET;
   logic             iHIT;
   logic [ADV_W-1:0] iHIT_BASES;
   logic             iWALK;
   logic             iOUT;
   logic [NBASE-1:0] oBASE;
   logic [NBASE-1:0] oCNT;
   logic [1:0]       oOUTS;
   logic [RUN_W-1:0] oRUNS;
   logic [ADV_W-1:0] oRUNS_EVT;
   logic             oINNING_END;
   logic             oERR;

   modport master (
      output iRESET, iHIT, iHIT_BASES, iWALK, iOUT,
      input  oBASE, oCNT, oOUTS, oRUNS, oRUNS_EVT, oINNING_END, oERR
   );

   modport slave (
      input  iRESET, iHIT, iHIT_BASES, iWALK, iOUT,
      output oBASE, oCNT, oOUTS, oRUNS, oRUNS_EVT, oINNING_END, oERR
   );
endinterface
`default_nettype wire

// File: rtl/base_adv.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------
// base_adv : combinational runner advance and runs-scored for one event
// Rev 1.0
// ---------------------------------------------------------------
module base_adv
   import base_pkg::*;
#(
   parameter int NBASE = NBASE_DEF,
   parameter int ADV_W = $clog2(NBASE + 2)
) (
   input  logic [NBASE-1:0] occ_i,
   input  event_e           ev_i,
   input  logic [ADV_W-1:0] k_i,
   output logic [NBASE-1:0] occ_o,
   output logic [ADV_W-1:0] runs_o
);
   logic chain;

   always_comb begin
      occ_o  = occ_i;
      runs_o = '0;
      chain  = 1'b1;
      case (ev_i)
         EV_HIT: begin
            if (int'(k_i) > NBASE) begin
               occ_o  = '0;
               runs_o = ADV_W'(1);
               for (int i = 0; i < NBASE; i++)
                  runs_o = runs_o + ADV_W'(occ_i[i]);
            end else if (k_i != '0) begin
               occ_o = '0;
               // Runner on bit i lands on bit i+k, or scores past the last base.
               for (int i = 0; i < NBASE; i++) begin
                  if (occ_i[i] && (i + 1 + int'(k_i) > NBASE))
                     runs_o = runs_o + ADV_W'(1);
                  for (int j = 0; j < NBASE; j++)
                     if (occ_i[i] && (i + int'(k_i) == j))
                        occ_o[j] = 1'b1;
               end
               for (int j = 0; j < NBASE; j++)
                  if (j + 1 == int'(k_i))
                     occ_o[j] = 1'b1;
            end
         end
         EV_WALK: begin
            // The push propagates only through an unbroken run of occupied bases.
            for (int i = 0; i < NBASE; i++) begin
               occ_o[i] = occ_i[i] | chain;
               chain    = chain & occ_i[i];
            end
            runs_o = ADV_W'(chain);
         end
         default: begin
            occ_o  = occ_i;
            runs_o = '0;
         end
      endcase
   end
endmodule
`default_nettype wire

// File: rtl/base_runner_tracker.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------
// base_runner_tracker : registered base occupancy, outs and run tally
// Rev 1.0
// ---------------------------------------------------------------
module base_runner_tracker
   import base_pkg::*;
#(
   parameter int NBASE = NBASE_DEF,
   parameter int RUN_W = RUN_W_DEF,
   parameter int ADV_W = $clog2(NBASE + 2)
) (
   input  logic                  iCLK,
   input  logic                  iRSTn,
   base_runner_tracker_if.slave  bus
);
   logic [NBASE-1:0] base_q, base_d;
   logic [NBASE-1:0] cnt_q,  cnt_d;
   logic [1:0]       outs_q, outs_d;
   logic [RUN_W-1:0] runs_q, runs_d;
   logic [ADV_W-1:0] evt_q,  evt_d;
   logic             end_q,  end_d;
   logic             err_q,  err_d;

   event_e           ev;
   logic [NBASE-1:0] adv_occ;
   logic [ADV_W-1:0] adv_runs;
   logic [RUN_W:0]   run_sum;
   int unsigned      pop;

   always_comb begin
      ev = EV_NONE;
      if (bus.iOUT)
         ev = PRIO_1ST;
      else if (bus.iHIT)
         ev = PRIO_2ND;
      else if (bus.iWALK)
         ev = PRIO_3RD;
      err_d = (bus.iOUT & bus.iHIT) | (bus.iOUT & bus.iWALK) | (bus.iHIT & bus.iWALK)
            | ((ev == EV_HIT) && (bus.iHIT_BASES == '0));
   end

   base_adv #(
      .NBASE (NBASE),
      .ADV_W (ADV_W)
   ) u_adv (
      .occ_i  (base_q),
      .ev_i   (ev),
      .k_i    (bus.iHIT_BASES),
      .occ_o  (adv_occ),
      .runs_o (adv_runs)
   );

   always_comb begin
      base_d = adv_occ;
      outs_d = outs_q;
      evt_d  = adv_runs;
      end_d  = 1'b0;
      if (ev == EV_OUT) begin
         evt_d = '0;
         if (outs_q == 2'(OUTS_PER_INNING - 1)) begin
            outs_d = '0;
            base_d = '0;
            end_d  = 1'b1;
         end else begin
            outs_d = outs_q + 2'd1;
         end
      end
      run_sum = {1'b0, runs_q} + (RUN_W+1)'(evt_d);
      runs_d  = run_sum[RUN_W] ? '1 : run_sum[RUN_W-1:0];
      if (!bus.iRESET) begin
         base_d = '0;
         outs_d = '0;
         evt_d  = '0;
         end_d  = 1'b0;
         runs_d = '0;
      end
      pop = 0;
      for (int i = 0; i < NBASE; i++)
         pop = pop + 32'(base_d[i]);
      for (int j = 0; j < NBASE; j++)
         cnt_d[j] = (pop > 32'(j));
   end

   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         base_q <= '0;
         cnt_q  <= '0;
         outs_q <= '0;
         runs_q <= '0;
         evt_q  <= '0;
         end_q  <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         base_q <= base_d;
         cnt_q  <= cnt_d;
         outs_q <= outs_d;
         runs_q <= runs_d;
         evt_q  <= evt_d;
         end_q  <= end_d;
         err_q  <= err_d & bus.iRESET;
      end
   end

   assign bus.oBASE       = base_q;
   assign bus.oCNT        = cnt_q;
   assign bus.oOUTS       = outs_q;
   assign bus.oRUNS       = runs_q;
   assign bus.oRUNS_EVT   = evt_q;
   assign bus.oINNING_END = end_q;
   assign bus.oERR        = err_q;
endmodule
`default_nettype wire
